// File: rtl/clock_time_counter_pkg.sv
// clock_time_counter_pkg: field limits, packed-word layout and range check for the HH:MM:SS clock
package clock_time_counter_pkg;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HOUR_MAX = 23;
  localparam int FIELD_W = 6;
  localparam int SS_LSB = 0;
  localparam int MM_LSB = 6;
  localparam int HH_LSB = 12;
  localparam int BLINK_BIT = 18;
  localparam int TIME_W = 3 * FIELD_W;
  function automatic logic time_valid(logic [TIME_W-1:0] t);
    return t[SS_LSB+:FIELD_W] <= FIELD_W'(SEC_MAX) && t[MM_LSB+:FIELD_W] <= FIELD_W'(MIN_MAX) &&
           t[HH_LSB+:FIELD_W] <= FIELD_W'(HOUR_MAX);
  endfunction
endpackage

// File: rtl/clock_time_counter_if.sv
// clock_time_counter_if: control/status bundle of the clock; CLOCK_ALARM_EN adds the alarm signals
interface clock_time_counter_if;
  import clock_time_counter_pkg::*;
  logic run_en, load, inc_min, inc_hour;
  logic [TIME_W-1:0] load_time;
  logic [TIME_W:0] num;
  logic sec_tick, day_wrap, load_err;
`ifdef CLOCK_ALARM_EN
  logic alarm_set, alarm;
  logic [TIME_W-1:0] alarm_time;
`endif
  modport master(
    output run_en, load, load_time, inc_min, inc_hour,
`ifdef CLOCK_ALARM_EN
    output alarm_set, alarm_time, input alarm,
`endif
    input num, sec_tick, day_wrap, load_err
  );
  modport slave(
    input run_en, load, load_time, inc_min, inc_hour,
`ifdef CLOCK_ALARM_EN
    input alarm_set, alarm_time, output alarm,
`endif
    output num, sec_tick, day_wrap, load_err
  );
endinterface

// File: rtl/clock_time_counter_wrap_counter.sv
// wrap_counter: 0..MAX counter with load priority over increment; carry marks the wrapping step
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         carry_o
);
  logic [W-1:0] value_q, value_d;
  always_comb begin
    carry_o = inc_i && value_q == W'(MAX);
    value_d = load_i ? load_val_i : carry_o ? '0 : inc_i ? value_q + 1'b1 : value_q;
  end
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else value_q <= value_d;
  end
  assign value_o = value_q;
endmodule

// File: rtl/clock_time_counter.sv
// clock_time_counter: 1 Hz prescaler and 24 h HH:MM:SS time feeding the 6-digit display.
// Optional CLOCK_ALARM_EN adds a range-checked alarm compare register and alarm pulse.
module clock_time_counter
  import clock_time_counter_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input logic clk,
  input logic rst,
  clock_time_counter_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic pend_q, pend_d, blink_q, sec_tick_q, day_wrap_q, load_err_q;
  logic tick, load_ok, do_inc, apply, err_d, ss_c, mm_c, hh_c, mm_inc, hh_inc;
  logic [FIELD_W-1:0] ss, mm, hh;
  always_comb begin
    tick = bus.run_en && presc_q == PW'(TICK_DIV - 1);
    load_ok = bus.load && time_valid(bus.load_time);
    do_inc = !bus.load && (bus.inc_min || bus.inc_hour);
    apply = !bus.load && !do_inc && (tick || pend_q);
    presc_d = load_ok || tick ? '0 : bus.run_en ? presc_q + 1'b1 : presc_q;
    // a tick blocked by a load or inc waits one bit deep until a free cycle
    pend_d = load_ok ? 1'b0 : apply ? pend_q && tick : pend_q || tick;
    mm_inc = do_inc ? bus.inc_min : ss_c;
    hh_inc = do_inc ? bus.inc_hour : mm_c;
    err_d = bus.load && !load_ok;
`ifdef CLOCK_ALARM_EN
    err_d = err_d || (bus.alarm_set && !time_valid(bus.alarm_time));
`endif
  end
  wrap_counter #(.MAX(SEC_MAX), .W(FIELD_W)) u_ss (
    .clk(clk), .rst(rst), .inc_i(apply), .load_i(load_ok),
    .load_val_i(bus.load_time[SS_LSB+:FIELD_W]), .value_o(ss), .carry_o(ss_c)
  );
  wrap_counter #(.MAX(MIN_MAX), .W(FIELD_W)) u_mm (
    .clk(clk), .rst(rst), .inc_i(mm_inc), .load_i(load_ok),
    .load_val_i(bus.load_time[MM_LSB+:FIELD_W]), .value_o(mm), .carry_o(mm_c)
  );
  wrap_counter #(.MAX(HOUR_MAX), .W(FIELD_W)) u_hh (
    .clk(clk), .rst(rst), .inc_i(hh_inc), .load_i(load_ok),
    .load_val_i(bus.load_time[HH_LSB+:FIELD_W]), .value_o(hh), .carry_o(hh_c)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pend_q <= 1'b0;
      blink_q <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pend_q <= pend_d;
      blink_q <= presc_d >= PW'(TICK_DIV / 2);
      sec_tick_q <= apply;
      day_wrap_q <= apply && hh_c;
      load_err_q <= err_d;
    end
  end
  always_comb begin
    bus.num = '0;
    bus.num[BLINK_BIT] = blink_q;
    bus.num[HH_LSB+:FIELD_W] = hh;
    bus.num[MM_LSB+:FIELD_W] = mm;
    bus.num[SS_LSB+:FIELD_W] = ss;
  end
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_wrap = day_wrap_q;
  assign bus.load_err = load_err_q;
`ifdef CLOCK_ALARM_EN
  logic [TIME_W-1:0] alm_q;
  always_ff @(posedge clk) begin
    if (rst) alm_q <= '0;
    else if (bus.alarm_set && time_valid(bus.alarm_time)) alm_q <= bus.alarm_time;
  end
  // only tick-applied times raise sec_tick, so loads and incs never match here
  assign bus.alarm = sec_tick_q && {hh, mm, ss} == alm_q;
`endif
endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: directed table, corner sequences and random stimulus vs a seconds-of-day model
module tb_clock_time_counter;
  localparam int TD = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  clock_time_counter_if bus();
  clock_time_counter #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, passes = 0;
  int m_t = 0, m_pc = 0;
  bit m_pend = 0;
  logic [18:0] e_num;
  logic e_sec, e_dw, e_err;

  typedef struct {
    logic r, run, ld;
    logic [17:0] lt;
    logic im, ih;
    logic [18:0] num;
    logic sec, dw, err;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [17:0] hms(int h, int m, int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction
  function automatic logic [18:0] n(bit b, int h, int m, int s);
    return {b, hms(h, m, s)};
  endfunction
  function automatic vec_t v(bit r, bit run, bit ld, logic [17:0] lt, bit im, bit ih,
                             logic [18:0] num, bit sec, bit dw, bit err);
    vec_t x;
    x = '{r, run, ld, lt, im, ih, num, sec, dw, err};
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // reference: time as seconds since midnight, prescaler phase, one pending tick
  task automatic model(bit r, bit run, bit ld, logic [17:0] lt, bit im, bit ih);
    int h, mi, s;
    bit tick, ok;
    tick = run && m_pc == TD - 1;
    ok = ld && lt[5:0] <= 59 && lt[11:6] <= 59 && lt[17:12] <= 23;
    e_sec = 0;
    e_dw = 0;
    e_err = !r && ld && !ok;
    if (r) begin
      m_t = 0; m_pc = 0; m_pend = 0;
    end else if (ok) begin
      m_t = int'(lt[17:12]) * 3600 + int'(lt[11:6]) * 60 + int'(lt[5:0]);
      m_pc = 0; m_pend = 0;
    end else begin
      if (ld || im || ih) begin
        if (!ld) begin
          h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
          if (im) mi = (mi + 1) % 60;
          if (ih) h = (h + 1) % 24;
          m_t = h * 3600 + mi * 60 + s;
        end
        m_pend = m_pend || tick;
      end else if (tick || m_pend) begin
        e_dw = m_t == 86399;
        m_t = (m_t + 1) % 86400;
        e_sec = 1;
        m_pend = (int'(m_pend) + int'(tick) - 1) > 0;
      end
      if (run) m_pc = (m_pc + 1) % TD;
    end
    e_num = {m_pc >= TD / 2, 6'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60)};
  endtask

  task automatic step(bit r, bit run, bit ld, logic [17:0] lt, bit im, bit ih);
    rst = r; bus.run_en = run; bus.load = ld; bus.load_time = lt;
    bus.inc_min = im; bus.inc_hour = ih;
    model(r, run, ld, lt, im, ih);
    @(posedge clk);
    #1;
    chk("num", 32'(bus.num), 32'(e_num));
    chk("sec_tick", 32'(bus.sec_tick), 32'(e_sec));
    chk("day_wrap", 32'(bus.day_wrap), 32'(e_dw));
    chk("load_err", 32'(bus.load_err), 32'(e_err));
  endtask

  initial begin
    bus.run_en = 0; bus.load = 0; bus.load_time = 0; bus.inc_min = 0; bus.inc_hour = 0;
`ifdef CLOCK_ALARM_EN
    bus.alarm_set = 0; bus.alarm_time = 0;
`endif
    tbl.push_back(v(1, 1, 0, 0, 0, 0, n(0, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 0, 0, 1), 1, 0, 0));
    tbl.push_back(v(0, 1, 1, hms(23, 59, 58), 0, 0, n(0, 23, 59, 58), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 23, 59, 58), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 23, 59, 58), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 23, 59, 58), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 23, 59, 59), 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 23, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 23, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 23, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 0, 0, 0), 1, 1, 0));
    tbl.push_back(v(0, 1, 1, hms(12, 60, 0), 0, 0, n(0, 0, 0, 0), 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 1, hms(10, 59, 59), 0, 0, n(0, 10, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 10, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 10, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 10, 59, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, n(0, 10, 0, 59), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 10, 1, 0), 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 1, n(1, 11, 2, 0), 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, n(1, 11, 2, 0), 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, n(1, 11, 2, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(1, 11, 2, 0), 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, n(0, 11, 2, 1), 1, 0, 0));
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].run, tbl[i].ld, tbl[i].lt, tbl[i].im, tbl[i].ih);
      chk($sformatf("tbl%0d_num", i), 32'(bus.num), 32'(tbl[i].num));
      chk($sformatf("tbl%0d_flags", i), 32'({bus.sec_tick, bus.day_wrap, bus.load_err}),
          32'({tbl[i].sec, tbl[i].dw, tbl[i].err}));
    end
    // mid-phase freeze for 10 cycles, then resume
    step(0, 1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0, 0, 0);
    // inc_hour wrap and inc_min wrap carry nothing
    step(0, 1, 1, hms(23, 59, 10), 0, 0);
    step(0, 1, 0, 0, 1, 1);
    chk("inc_wrap", 32'(bus.num[17:0]), 32'(hms(0, 0, 10)));
    // reset with a pending tick discards it
    step(0, 1, 1, hms(5, 17, 33), 0, 0);
    for (int k = 0; k < 8 && m_pc != TD - 1; k++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("rst_num", 32'(bus.num), 32'(0));
    chk("rst_flags", 32'({bus.sec_tick, bus.day_wrap, bus.load_err}), 32'(0));
    step(0, 1, 0, 0, 0, 0);
    chk("pend_drop_num", 32'(bus.num), 32'(0));
    chk("pend_drop_sec", 32'(bus.sec_tick), 32'(0));
    for (int c = 0; c < 3000; c++) begin
      logic [17:0] lt;
      int sel;
      sel = $urandom_range(0, 3);
      lt = sel == 0 ? hms(23, 59, $urandom_range(55, 59)) :
           sel == 1 ? 18'($urandom) :
           hms($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           lt, $urandom_range(0, 14) == 0, $urandom_range(0, 19) == 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
